// File: rtl/gray_stream_decoder.sv
// Gray-coded count stream receiver: decodes each accepted word to binary through
// one output register stage and flags any word that is not the previous value + 1.
module gray_stream_decoder #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  input  logic             resync,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] BIN_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_bin_q,   out_bin_d;
  logic             step_err_q,  step_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             have_prev_q, have_prev_d;
  logic [WIDTH-1:0] prev_bin_q,  prev_bin_d;

  logic             accept_s;
  logic [WIDTH-1:0] decoded_s;
  logic [WIDTH-1:0] expect_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign decoded_s = gray2bin(in_gray);
  assign expect_s  = prev_bin_q + BIN_ONE;

  // Next-state: load on accept, drain when consumed, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_bin_d   = out_bin_q;
    step_err_d  = step_err_q;
    err_count_d = err_count_q;
    have_prev_d = have_prev_q;
    prev_bin_d  = prev_bin_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_bin_d   = decoded_s;
      // A coincident resync means this word starts a fresh sequence.
      step_err_d  = have_prev_q && !resync && (decoded_s != expect_s);
      prev_bin_d  = decoded_s;
      have_prev_d = 1'b1;
      if (step_err_d && (err_count_q != ERR_MAX)) begin
        err_count_d = err_count_q + ERR_ONE;
      end else begin
        err_count_d = err_count_q;
      end
    end else begin
      if (out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (resync) begin
        have_prev_d = 1'b0;
      end else begin
        have_prev_d = have_prev_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_bin_q   <= {WIDTH{1'b0}};
      step_err_q  <= 1'b0;
      err_count_q <= {ERR_W{1'b0}};
      have_prev_q <= 1'b0;
      prev_bin_q  <= {WIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
      have_prev_q <= have_prev_d;
      prev_bin_q  <= prev_bin_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Directed bench for gray_stream_decoder: two instances (ERR_W=8 and ERR_W=2)
// share one input stream so counter saturation is observed alongside normal counting.
module tb_gray_stream_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_gray = 4'd0;
  logic       resync = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready_a, out_valid_a, step_err_a;
  logic [3:0] out_bin_a;
  logic [7:0] err_count_a;
  logic       in_ready_b, out_valid_b, step_err_b;
  logic [3:0] out_bin_b;
  logic [1:0] err_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int exp8  = 0;
  int exp2  = 0;

  gray_stream_decoder #(.WIDTH(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_gray(in_gray), .resync(resync), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_bin(out_bin_a), .step_err(step_err_a),
    .err_count(err_count_a)
  );

  gray_stream_decoder #(.WIDTH(4), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_gray(in_gray), .resync(resync), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_bin(out_bin_b), .step_err(step_err_b),
    .err_count(err_count_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " err_count8"}, {24'd0, err_count_a}, exp8);
    chk({tag, " err_count2"}, {30'd0, err_count_b}, exp2);
  endtask

  // Offer one word with out_ready=1; it must be accepted and show up next cycle.
  task automatic send(input string tag, input logic [3:0] g, input logic rs,
                      input logic [3:0] eb, input logic ee);
    in_valid  = 1'b1;
    in_gray   = g;
    resync    = rs;
    out_ready = 1'b1;
    #1;
    chk({tag, " in_ready"}, {31'd0, in_ready_a}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    resync   = 1'b0;
    if (ee) exp8++;
    exp2 = (exp8 > 3) ? 3 : exp8;
    chk({tag, " out_valid"}, {31'd0, out_valid_a}, 32'd1);
    chk({tag, " out_bin"}, {28'd0, out_bin_a}, {28'd0, eb});
    chk({tag, " step_err"}, {31'd0, step_err_a}, {31'd0, ee});
    chk({tag, " step_err2"}, {31'd0, step_err_b}, {31'd0, ee});
    chk_counts(tag);
  endtask

  task automatic idle(input logic rdy, input logic rs);
    in_valid  = 1'b0;
    out_ready = rdy;
    resync    = rs;
    @(posedge clk);
    #1;
    resync = 1'b0;
  endtask

  logic [3:0] gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst out_bin", {28'd0, out_bin_a}, 32'd0);
    chk("rst step_err", {31'd0, step_err_a}, 32'd0);
    chk_counts("rst");
    rst = 1'b0;
    chk("rst in_ready", {31'd0, in_ready_a}, 32'd1);

    // Case 1: full counting stream, one word per cycle
    for (int i = 0; i < 16; i++) begin
      send("count", gray_seq[i], 1'b0, 4'(i), 1'b0);
    end

    // Case 2: wrap-around 15 -> 0 -> 1
    send("wrap0", 4'd0, 1'b0, 4'd0, 1'b0);
    send("wrap1", 4'd1, 1'b0, 4'd1, 1'b0);

    // Case 3: skip and repeat
    send("pre2", 4'd3, 1'b0, 4'd2, 1'b0);
    send("pre3", 4'd2, 1'b0, 4'd3, 1'b0);
    send("skip5", 4'd7, 1'b0, 4'd5, 1'b1);
    send("rep5", 4'd7, 1'b0, 4'd5, 1'b1);
    send("ok6", 4'd5, 1'b0, 4'd6, 1'b0);

    // Drain the pending word
    idle(1'b1, 1'b0);
    chk("drain out_valid", {31'd0, out_valid_a}, 32'd0);

    // Case 4: backpressure with Gray 6 (binary 4, an error after 6)
    in_valid  = 1'b1;
    in_gray   = 4'd6;
    out_ready = 1'b0;
    #1;
    chk("bp first in_ready", {31'd0, in_ready_a}, 32'd1);
    @(posedge clk);
    #1;
    exp8++;
    exp2 = (exp8 > 3) ? 3 : exp8;
    chk("bp out_bin", {28'd0, out_bin_a}, 32'd4);
    chk("bp step_err", {31'd0, step_err_a}, 32'd1);
    chk_counts("bp");
    for (int k = 0; k < 5; k++) begin
      chk("bp in_ready", {31'd0, in_ready_a}, 32'd0);
      @(posedge clk);
      #1;
      chk("bp hold valid", {31'd0, out_valid_a}, 32'd1);
      chk("bp hold bin", {28'd0, out_bin_a}, 32'd4);
      chk("bp hold err", {31'd0, step_err_a}, 32'd1);
      chk_counts("bp hold");
    end
    // Drain and accept in the same cycle
    send("bp release", 4'd7, 1'b0, 4'd5, 1'b0);

    // Case 5: error (5 -> 2), then resync, then unchecked first word
    send("pre resync", 4'd3, 1'b0, 4'd2, 1'b1);
    idle(1'b1, 1'b1);
    chk("resync out_valid", {31'd0, out_valid_a}, 32'd0);
    chk_counts("resync");
    send("resync first", 4'd12, 1'b0, 4'd8, 1'b0);
    send("resync next", 4'd13, 1'b0, 4'd9, 1'b0);
    // resync coincident with accept: word unchecked but becomes prev
    send("resync+acc", 4'd0, 1'b1, 4'd0, 1'b0);
    send("after coinc", 4'd1, 1'b0, 4'd1, 1'b0);
    send("after coinc2", 4'd3, 1'b0, 4'd2, 1'b0);

    // Case 6: more errors; ERR_W=2 instance holds at 3
    send("sat a", 4'd7, 1'b0, 4'd5, 1'b1);
    send("sat b", 4'd7, 1'b0, 4'd5, 1'b1);
    send("sat c", 4'd7, 1'b0, 4'd5, 1'b1);
    chk("sat hold2", {30'd0, err_count_b}, 32'd3);

    // Reset while a word is pending
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    exp8 = 0;
    exp2 = 0;
    chk("mid rst out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("mid rst out_valid2", {31'd0, out_valid_b}, 32'd0);
    chk_counts("mid rst");
    send("post rst first", 4'd10, 1'b0, 4'd12, 1'b0);
    send("post rst next", 4'd11, 1'b0, 4'd13, 1'b0);
    send("post rst err", 4'd8, 1'b0, 4'd15, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_stream_decoder.md
Name: gray_stream_decoder

Overview:
Receiving end of a Gray-coded count stream, such as a pointer or position counter produced by the team's bin2gray encoder. It accepts one WIDTH-bit Gray word per valid/ready handshake and decodes it to binary through a registered output stage. It checks that each accepted word is exactly the previous value plus one, modulo 2^WIDTH, and keeps a saturating error counter. It sits between a Gray-coded source and binary consumer logic.

Parameters:
WIDTH, 4, bit width of the Gray input and the binary output (must be at least 2)
ERR_W, 8, width of the saturating step-error counter

Ports:
clk  input  1  rising-edge clock; the only clock in the block
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a Gray word on in_gray
in_ready  output  1  block can accept in_gray this cycle
in_gray  input  WIDTH  Gray-coded input word
resync  input  1  one-cycle pulse: forget the previous value; the next accepted word is not checked
out_valid  output  1  out_bin / step_err hold a decoded word
out_ready  input  1  downstream accepts the output word this cycle
out_bin  output  WIDTH  binary decode of the accepted Gray word
step_err  output  1  qualified by out_valid; word was not previous+1
err_count  output  ERR_W  number of step errors since reset; saturates at all-ones

Behaviour:
- Reset values, applied when rst=1 at a clk edge:
  - out_valid=0, out_bin=0, step_err=0, err_count=0.
  - Internal have_prev=0 and prev_bin=0.
- rst has priority over every other input.
- in_ready = !out_valid || out_ready. It is combinational, with no combinational path from in_valid.
- Accept condition: in_valid && in_ready at the clk edge.
- Output register: one register stage, so latency is 1 cycle from acceptance to out_valid.
  - out_valid sets on accept.
  - out_valid clears when out_ready=1 and no new word is accepted in that cycle.
  - Simultaneous drain and accept in one cycle is allowed, giving full throughput of one word per cycle.
- Output stability: while out_valid=1 and out_ready=0, out_bin, step_err and out_valid hold stable.
- Decode rule: out_bin[WIDTH-1] = in_gray[WIDTH-1]; out_bin[i] = out_bin[i+1] ^ in_gray[i].
- Step check on accept:
  - If have_prev=1, step_err = (decoded != prev_bin + 1). The addition is modulo 2^WIDTH, so all-ones followed by 0 is legal.
  - If have_prev=0, step_err = 0.
- On every accept: prev_bin <= decoded and have_prev <= 1.
- Repeated word: an identical word accepted twice in a row counts as an error.
- err_count increments by 1 in the cycle step_err is registered as 1. It holds at 2^ERR_W-1 and does not wrap.
- resync:
  - When resync=1 with no accept in the same cycle, have_prev <= 0.
  - When resync and an accept coincide, the accepted word is not checked (step_err=0), and that word becomes prev_bin with have_prev=1.
  - resync does not affect out_valid or err_count.
- Reset mid-transfer: a pending output word is discarded (out_valid=0). The first word after reset is unchecked.

Test Plan:
1. Counting stream: reset, then send Gray 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 with out_ready=1 throughout.
   - out_bin = 0..15 in order, each 1 cycle after acceptance.
   - step_err=0 on every word; err_count=0.
2. Wrap-around: continue after case 1 with Gray 0 then Gray 1.
   - out_bin = 0, 1 with step_err=0 on both; err_count stays 0.
3. Skip and repeat: after binary 3 (Gray 2), send Gray 7 (binary 5), then Gray 7 again, then Gray 5 (binary 6).
   - step_err = 1, 1, 0 respectively; err_count = 2.
4. Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 with Gray 6.
   - in_ready=0 after the first accept, and out_bin=4 holds stable.
   - Raise out_ready: the pending word drains, and the next word is accepted in the same cycle.
5. Resync and first word: pulse resync, then send Gray 12 (binary 8) after prev=2.
   - step_err=0, err_count unchanged.
   - The next word must be binary 9 for step_err=0.
6. Saturation and reset: with ERR_W=2, inject 5 step errors.
   - err_count reads 3 and holds.
   - Assert rst while out_valid=1: out_valid=0 and err_count=0 next cycle, and the next word is unchecked.
